mac_accum_ctrl: RTL and testbench

Sequencing and accumulation stage directly downstream of the Booth multiplier (booth_fsm + booth_datapath) in the MAC unit. Accepts operand pairs over a valid/ready stream and issues each pair to the multiplier. On multiplier ready it captures the 2*DATA_WIDTH product, sign-extends it and accumulates it into an ACC_WIDTH register. On the last term of a burst it presents the sum with a sticky overflow flag and a term count over a valid/ready output.

---
 rtl/mac_accum_ctrl.sv | 128 ++++++++++++
 tb/tb_mac_accum_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accum_ctrl.sv
// Sequencing/accumulation stage behind the Booth multiplier.
// Issues one operand pair at a time to the multiplier, then sign-extends and
// accumulates each product. The burst sum is presented on a valid/ready output
// together with a sticky overflow flag and a term count.
`timescale 1ns/1ps
module mac_accum_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned CNT_WIDTH  = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  input  logic                    in_last,
  input  logic                    clr,
  output logic                    mul_start,
  output logic [DATA_WIDTH-1:0]   mul_m,
  output logic [DATA_WIDTH-1:0]   mul_q,
  input  logic                    mul_ready,
  input  logic [2*DATA_WIDTH-1:0] mul_product,
  output logic                    acc_valid,
  input  logic                    acc_ready,
  output logic [ACC_WIDTH-1:0]    acc_out,
  output logic                    acc_ovf,
  output logic [CNT_WIDTH-1:0]    term_cnt
);

  localparam int unsigned ProdWidth = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StAccum, StOutput} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   a_q, b_q;
  logic                    last_q;
  logic [ProdWidth-1:0]    prod_q;
  logic [ACC_WIDTH-1:0]    acc_q;
  logic                    ovf_q;
  logic [CNT_WIDTH-1:0]    cnt_q;

  logic                    accept;
  logic [ACC_WIDTH-1:0]    prod_ext;
  logic [ACC_WIDTH-1:0]    acc_sum;
  logic                    ovf_now;
  logic [CNT_WIDTH-1:0]    cnt_inc;

  assign accept   = in_valid && in_ready;
  // Signed cast before the size cast so the product is sign-extended.
  assign prod_ext = ACC_WIDTH'($signed(prod_q));
  assign acc_sum  = acc_q + prod_ext;
  // Same-sign addends with a differently signed result means signed overflow.
  assign ovf_now  = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                    (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; mul_ready outside WAIT is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (accept) state_d = StIssue;
      StIssue:  state_d = StWait;
      StWait:   if (mul_ready) state_d = StAccum;
      StAccum:  state_d = last_q ? StOutput : StIdle;
      StOutput: if (acc_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; operands held in registers until the next accept.
  always_comb begin
    in_ready  = (state_q == StIdle);
    mul_start = (state_q == StIssue);
    acc_valid = (state_q == StOutput);
    mul_m     = a_q;
    mul_q     = b_q;
    acc_out   = acc_q;
    acc_ovf   = ovf_q;
    term_cnt  = cnt_q;
  end

  // Operand latch on accept and product capture on the multiplier done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      last_q <= 1'b0;
      prod_q <= '0;
    end else begin
      if (accept) begin
        a_q    <= in_a;
        b_q    <= in_b;
        last_q <= in_last;
      end
      if (state_q == StWait && mul_ready) begin
        prod_q <= mul_product;
      end
    end
  end

  // Accumulator, sticky overflow and saturating term count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else if ((state_q == StIdle && clr) || (state_q == StOutput && acc_ready)) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else if (state_q == StAccum) begin
      acc_q <= acc_sum;
      ovf_q <= ovf_q | ovf_now;
      cnt_q <= cnt_inc;
    end
  end

endmodule

// File: tb/tb_mac_accum_ctrl.sv
// Bench for mac_accum_ctrl: behavioural 18-cycle multiplier, directed vector
// table, hand-written corner sequences and random bursts against a reference.
`timescale 1ns/1ps
module tb_mac_accum_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last, clr;
  logic [15:0] in_a, in_b;
  logic        mul_start, mul_ready;
  logic [15:0] mul_m, mul_q;
  logic [31:0] mul_product;
  logic        acc_valid, acc_ready, acc_ovf;
  logic [39:0] acc_out;
  logic [9:0]  term_cnt;

  mac_accum_ctrl #(.DATA_WIDTH(16), .ACC_WIDTH(40), .CNT_WIDTH(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .clr(clr),
    .mul_start(mul_start), .mul_m(mul_m), .mul_q(mul_q),
    .mul_ready(mul_ready), .mul_product(mul_product),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_out(acc_out),
    .acc_ovf(acc_ovf), .term_cnt(term_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: done pulse 18 cycles after the start cycle, with product.
  int               mul_cnt = 0;
  int               start_cnt = 0;
  logic             spur_req = 1'b0;
  logic signed [31:0] pend = '0;
  always @(negedge clk) begin
    if (mul_start) start_cnt <= start_cnt + 1;
    if (!rst_n) begin
      mul_cnt   <= 0;
      mul_ready <= 1'b0;
    end else begin
      mul_ready <= 1'b0;
      if (spur_req) begin
        mul_ready   <= 1'b1;
        mul_product <= 32'h1234_5678;
      end else if (mul_cnt == 1) begin
        mul_ready   <= 1'b1;
        mul_product <= pend;
        mul_cnt     <= 0;
      end else if (mul_cnt > 1) begin
        mul_cnt <= mul_cnt - 1;
      end else if (mul_start) begin
        mul_cnt <= 18;
        pend    <= $signed(mul_m) * $signed(mul_q);
      end
    end
  end

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: exact sum folded into the 40-bit signed range per term.
  longint ref_acc = 0;
  logic   ref_ovf = 1'b0;
  int     ref_cnt = 0;

  task automatic ref_clear();
    ref_acc = 0; ref_ovf = 1'b0; ref_cnt = 0;
  endtask

  task automatic ref_add(input longint p);
    longint e;
    e = ref_acc + p;
    if (e > 64'sd549755813887) begin
      e = e - 64'sd1099511627776; ref_ovf = 1'b1;
    end else if (e < -64'sd549755813888) begin
      e = e + 64'sd1099511627776; ref_ovf = 1'b1;
    end
    ref_acc = e;
    if (ref_cnt < 1023) ref_cnt++;
  endtask

  task automatic chk_ref();
    logic [39:0] bits;
    bits = ref_acc[39:0];
    chk("acc_out_ref", acc_out, bits);
    chk("acc_ovf_ref", acc_ovf, ref_ovf);
    chk("term_cnt_ref", term_cnt, ref_cnt);
  endtask

  // Offer one term, then wait until back in IDLE or presenting a result.
  task automatic send_term(input logic signed [15:0] a, input logic signed [15:0] b,
                           input logic last, input logic c, output int lat);
    int n, t0, s0;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last; clr = c;
    t0 = cyc; s0 = start_cnt;
    @(posedge clk); #1;
    in_valid = 1'b0; clr = 1'b0;
    chk("in_ready_busy", in_ready, 0);
    if (c) ref_clear();
    ref_add(longint'(a) * longint'(b));
    n = 0;
    while (!(in_ready || acc_valid) && n < 60) begin @(posedge clk); #1; n++; end
    chk("term_done", in_ready || acc_valid, 1);
    chk("mul_start_pulses", start_cnt - s0, 1);
    lat = cyc - t0;
  endtask

  task automatic finish_out();
    acc_ready = 1'b1;
    @(posedge clk); #1;
    acc_ready = 1'b0;
    chk("valid_drop", acc_valid, 0);
    chk("acc_cleared", acc_out, 0);
    chk("cnt_cleared", term_cnt, 0);
    ref_clear();
  endtask

  typedef struct {
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic               last;
    int                 hold;
    logic [39:0]        exp_acc;
    logic               exp_ovf;
    logic [9:0]         exp_cnt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    logic [39:0] held;
    vecs[0] = '{16'sd3,   -16'sd4, 1'b1, 0, 40'hFF_FFFF_FFF4, 1'b0, 10'd1};
    vecs[1] = '{16'sd100, 16'sd200, 1'b0, 0, 40'h0, 1'b0, 10'd0};
    vecs[2] = '{-16'sd50, 16'sd40,  1'b0, 0, 40'h0, 1'b0, 10'd0};
    vecs[3] = '{16'sd7,   16'sd7,   1'b1, 5, 40'h00_0000_4681, 1'b0, 10'd3};
    vecs[4] = '{16'sd2,   16'sd3,   1'b1, 0, 40'h6, 1'b0, 10'd1};
    vecs[5] = '{-16'sd1,  16'sd1,   1'b1, 2, 40'hFF_FFFF_FFFF, 1'b0, 10'd1};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
    clr = 1'b0; acc_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_acc_valid", acc_valid, 0);
    chk("rst_acc_out", acc_out, 0);
    chk("rst_cnt", term_cnt, 0);
    chk("rst_mul_m", {mul_m, mul_q}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table: latency, sum, count, optional backpressure.
    foreach (vecs[i]) begin
      send_term(vecs[i].a, vecs[i].b, vecs[i].last, 1'b0, lat);
      if (vecs[i].last) begin
        chk("latency", lat, 21);
        chk("acc_valid", acc_valid, 1);
        chk("acc_out", acc_out, vecs[i].exp_acc);
        chk("acc_ovf", acc_ovf, vecs[i].exp_ovf);
        chk("term_cnt", term_cnt, vecs[i].exp_cnt);
        held = acc_out;
        for (int k = 0; k < vecs[i].hold; k++) begin
          @(posedge clk); #1;
          chk("bp_valid", acc_valid, 1);
          chk("bp_acc", acc_out, held);
          chk("bp_in_ready", in_ready, 0);
        end
        finish_out();
      end
    end

    // Overflow: 512 x (-32768)^2 = 2^39 wraps to the most negative value.
    for (int k = 0; k < 512; k++) send_term(-16'sd32768, -16'sd32768, k == 511, 1'b0, lat);
    chk("ovf_acc", acc_out, 40'h80_0000_0000);
    chk("ovf_flag", acc_ovf, 1);
    chk("ovf_cnt", term_cnt, 512);
    chk_ref();
    finish_out();
    chk("ovf_cleared", acc_ovf, 0);

    // clr together with accept: new term lands on zero.
    send_term(16'sd5, 16'sd5, 1'b0, 1'b0, lat);
    chk("pre_clr_acc", acc_out, 25);
    send_term(16'sd2, 16'sd3, 1'b1, 1'b1, lat);
    chk("clr_acc", acc_out, 6);
    chk("clr_cnt", term_cnt, 1);
    finish_out();

    // Reset during WAIT, then a spurious done pulse in IDLE.
    in_valid = 1'b1; in_a = 16'd1; in_b = 16'd2; in_last = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_valid", acc_valid, 0);
    chk("mid_rst_start", mul_start, 0);
    chk("mid_rst_ops", {mul_m, mul_q}, 0);
    chk("mid_rst_acc", acc_out, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    ref_clear();
    spur_req = 1'b1;
    @(posedge clk); #1 spur_req = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("spur_in_ready", in_ready, 1);
    chk("spur_valid", acc_valid, 0);
    chk("spur_cnt", term_cnt, 0);
    send_term(16'sd1, 16'sd1, 1'b1, 1'b0, lat);
    chk("post_rst_acc", acc_out, 1);
    chk("post_rst_latency", lat, 21);
    finish_out();

    // Random bursts against the reference model.
    for (int bst = 0; bst < 8; bst++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        send_term(16'($urandom), 16'($urandom), k == len - 1,
                  (k == 0) ? 1'($urandom_range(0, 1)) : 1'b0, lat);
      end
      chk("rnd_latency", lat, 21);
      chk_ref();
      finish_out();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
